// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and instruction field positions for the hazard / forwarding
// unit and its scoreboard.
//   fwd_sel_e  : per-source forwarding select (register file, WB, MEM)
//   hz_state_e : load-use stall FSM states
//   *_LSB      : bit positions of rd and the source register fields
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } hz_state_e;

    localparam int RD_LSB   = 7;
    localparam int SRC0_LSB = 15;
    localparam int SRC1_LSB = 20;
    localparam int SRC2_LSB = 27;

    // Bit position of source field idx inside a 32-bit instruction.
    function automatic int src_lsb(input int idx);
        case (idx)
            0:       return SRC0_LSB;
            1:       return SRC1_LSB;
            default: return SRC2_LSB;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// One pending bit per architectural register for long-latency results.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all bits)
//   set_en/set_addr : mark a register pending (wins over a same-cycle clear)
//   clr_en/clr_addr : retire a pending register
//   rd_addr         : NUM_RD lookup addresses, read combinationally
//   rd_hit          : pending bit for each lookup (register 0 never hits)
//   sb_busy         : at least one pending bit set (registered view)
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int NUM_RD = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_en,
    input  logic [REG_AW-1:0]              set_addr,
    input  logic                           clr_en,
    input  logic [REG_AW-1:0]              clr_addr,
    input  logic [NUM_RD-1:0][REG_AW-1:0]  rd_addr,
    output logic [NUM_RD-1:0]              rd_hit,
    output logic                           sb_busy
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;

    // Clear first so a same-cycle set of the same register wins.
    // Register 0 is hard-wired and is never tracked.
    always_comb begin
        pending_next = pending_reg;
        if (clr_en && (clr_addr != '0)) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            pending_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            assign rd_hit[gi] = (rd_addr[gi] != '0) && pending_reg[rd_addr[gi]];
        end
    endgenerate

    assign sb_busy = |pending_reg;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// EX-stage forwarding selects, load-use stall FSM and long-latency
// scoreboard interlock.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id/ex/mem/wb_inst        : instructions in each pipeline stage
//   ex_memread               : EX instruction is a load
//   mem_regwrite/wb_regwrite : MEM / WB instruction writes its rd
//   lld_issue                : long-latency op issues from EX (rd = ex rd)
//   lld_done, lld_rd         : long-latency result retires to lld_rd
//   forward                  : 2 bits per source, 10=MEM, 01=WB, 00=regfile
//   stall, flush_ex          : hold PC/IF-ID and bubble ID/EX (identical)
//   sb_busy                  : some long-latency result still outstanding
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            id_inst,
    input  logic [31:0]            ex_inst,
    input  logic                   ex_memread,
    input  logic [31:0]            mem_inst,
    input  logic                   mem_regwrite,
    input  logic [31:0]            wb_inst,
    input  logic                   wb_regwrite,
    input  logic                   lld_issue,
    input  logic                   lld_done,
    input  logic [REG_AW-1:0]      lld_rd,
    output logic [2*NUM_SRC-1:0]   forward,
    output logic                   stall,
    output logic                   flush_ex,
    output logic                   sb_busy
);

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;

    assign id_rd  = id_inst[RD_LSB +: REG_AW];
    assign ex_rd  = ex_inst[RD_LSB +: REG_AW];
    assign mem_rd = mem_inst[RD_LSB +: REG_AW];
    assign wb_rd  = wb_inst[RD_LSB +: REG_AW];

    // Opcode and funct bits are deliberately not decoded.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{id_inst, ex_inst, mem_inst, wb_inst};

    logic [2*NUM_SRC-1:0]              fwd_raw;
    logic [NUM_SRC-1:0]                lu_match;
    logic [NUM_SRC:0][REG_AW-1:0]      sb_addr;
    logic [NUM_SRC:0]                  sb_hit;

    // Per-source forwarding comparators and ID-source hazard compares.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam int LSB = src_lsb(gi);
            logic [REG_AW-1:0] ex_src;
            logic [REG_AW-1:0] id_src;
            fwd_sel_e          sel;

            assign ex_src = ex_inst[LSB +: REG_AW];
            assign id_src = id_inst[LSB +: REG_AW];

            // MEM holds the younger result, so it beats WB.
            always_comb begin
                sel = FWD_REG;
                if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src)) begin
                    sel = FWD_MEM;
                end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_src)) begin
                    sel = FWD_WB;
                end
            end

            assign fwd_raw[2*gi +: 2] = sel;
            assign lu_match[gi]       = (id_src == ex_rd);
            assign sb_addr[gi]        = id_src;
        end
    endgenerate

    // The ID destination is also checked so a WAW against a pending
    // long-latency write cannot overtake it.
    assign sb_addr[NUM_SRC] = id_rd;

    logic lu_haz;
    logic sb_haz;
    logic sb_set;

    assign lu_haz = ex_memread && (ex_rd != '0) && (|lu_match);
    assign sb_haz = |sb_hit;

    // A flushed EX slot is a bubble, so its issue must not be recorded.
    assign sb_set = lld_issue && !flush_ex;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .NUM_RD (NUM_SRC + 1)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (ex_rd),
        .clr_en   (lld_done),
        .clr_addr (lld_rd),
        .rd_addr  (sb_addr),
        .rd_hit   (sb_hit),
        .sb_busy  (sb_busy)
    );

    // Load-use stall FSM. The IDLE cycle that detects the hazard is the
    // first stall cycle; LSTALL supplies the remaining LOAD_LAT-1.
    hz_state_e  state_reg;
    hz_state_e  state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       stall_fsm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_fsm  = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_fsm = lu_haz || sb_haz;
                cnt_next  = '0;
                if (lu_haz && (LOAD_LAT > 1)) begin
                    state_next = LSTALL;
                    cnt_next   = LAT_M1;
                end
            end
            LSTALL: begin
                stall_fsm = 1'b1;
                cnt_next  = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign stall    = !rst && stall_fsm;
    assign flush_ex = stall;
    assign forward  = rst ? '0 : fwd_raw;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Drives three instances (NUM_SRC/LOAD_LAT = 2/1, 3/3, 3/4) from shared
// stimulus: a directed prologue followed by random cycles. A reference
// model computes expected outputs per cycle and pushes them into a queue;
// a monitor on the falling edge pops and compares.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_inst = '0;
    logic [31:0] ex_inst = '0;
    logic        ex_memread = 1'b0;
    logic [31:0] mem_inst = '0;
    logic        mem_regwrite = 1'b0;
    logic [31:0] wb_inst = '0;
    logic        wb_regwrite = 1'b0;
    logic        lld_issue = 1'b0;
    logic        lld_done = 1'b0;
    logic [4:0]  lld_rd = '0;

    logic [3:0] fwd_a;
    logic [5:0] fwd_b;
    logic [5:0] fwd_c;
    logic       stall_a, stall_b, stall_c;
    logic       flush_a, flush_b, flush_c;
    logic       busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst),
        .ex_memread(ex_memread), .mem_inst(mem_inst), .mem_regwrite(mem_regwrite),
        .wb_inst(wb_inst), .wb_regwrite(wb_regwrite), .lld_issue(lld_issue),
        .lld_done(lld_done), .lld_rd(lld_rd), .forward(fwd_a), .stall(stall_a),
        .flush_ex(flush_a), .sb_busy(busy_a));

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(3), .LOAD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst),
        .ex_memread(ex_memread), .mem_inst(mem_inst), .mem_regwrite(mem_regwrite),
        .wb_inst(wb_inst), .wb_regwrite(wb_regwrite), .lld_issue(lld_issue),
        .lld_done(lld_done), .lld_rd(lld_rd), .forward(fwd_b), .stall(stall_b),
        .flush_ex(flush_b), .sb_busy(busy_b));

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(3), .LOAD_LAT(4)) dut_c (
        .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst),
        .ex_memread(ex_memread), .mem_inst(mem_inst), .mem_regwrite(mem_regwrite),
        .wb_inst(wb_inst), .wb_regwrite(wb_regwrite), .lld_issue(lld_issue),
        .lld_done(lld_done), .lld_rd(lld_rd), .forward(fwd_c), .stall(stall_c),
        .flush_ex(flush_c), .sb_busy(busy_c));

    typedef struct packed {
        logic [5:0] fwd;
        logic       stall;
        logic       flush;
        logic       busy;
    } exp1_t;
    typedef exp1_t [2:0] expv_t;

    expv_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cycle_no = 0;

    // Reference model state: per instance pending set and remaining load
    // stall cycles after the current one.
    int          m_nsrc[3] = '{2, 3, 3};
    int          m_lat[3]  = '{1, 3, 4};
    int          m_lsb[3]  = '{15, 20, 27};
    logic [31:0] m_pend[3] = '{32'h0, 32'h0, 32'h0};
    int          m_rem[3]  = '{0, 0, 0};

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] s0,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {s2, 2'b00, s1, s0, 3'b000, rd, 7'b0000011};
    endfunction

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rinst();
        logic [31:0] v;
        v = $urandom;
        v[11:7]  = rreg();
        v[19:15] = rreg();
        v[24:20] = rreg();
        v[31:27] = rreg();
        return v;
    endfunction

    // Expected outputs for the inputs now on the pins, then advance model.
    task automatic issue_cycle();
        expv_t      e;
        logic [4:0] exrd, idrd, memrd, wbrd, es, is;
        logic       lu, sb;
        exrd  = ex_inst[11:7];
        idrd  = id_inst[11:7];
        memrd = mem_inst[11:7];
        wbrd  = wb_inst[11:7];
        for (int d = 0; d < 3; d++) begin
            e[d] = '0;
            lu = 1'b0;
            sb = (idrd != 0) && m_pend[d][idrd];
            for (int i = 0; i < m_nsrc[d]; i++) begin
                es = ex_inst[m_lsb[i] +: 5];
                is = id_inst[m_lsb[i] +: 5];
                if (!rst) begin
                    if (mem_regwrite && memrd != 0 && memrd == es)
                        e[d].fwd[2*i +: 2] = 2'b10;
                    else if (wb_regwrite && wbrd != 0 && wbrd == es)
                        e[d].fwd[2*i +: 2] = 2'b01;
                end
                if (ex_memread && exrd != 0 && exrd == is) lu = 1'b1;
                if (is != 0 && m_pend[d][is]) sb = 1'b1;
            end
            if (!rst) e[d].stall = (m_rem[d] > 0) || lu || sb;
            e[d].flush = e[d].stall;
            e[d].busy  = (m_pend[d] != 0);
            if (rst) begin
                m_pend[d] = '0;
                m_rem[d]  = 0;
            end else begin
                if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
                else if (lu)      m_rem[d] = m_lat[d] - 1;
                if (lld_done && lld_rd != 0) m_pend[d][lld_rd] = 1'b0;
                if (lld_issue && !e[d].stall && exrd != 0) m_pend[d][exrd] = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic r, input logic [31:0] idi, input logic [31:0] exi,
                       input logic exm, input logic [31:0] memi, input logic memw,
                       input logic [31:0] wbi, input logic wbw, input logic iss,
                       input logic done, input logic [4:0] lrd);
        @(posedge clk);
        #1;
        rst = r; id_inst = idi; ex_inst = exi; ex_memread = exm;
        mem_inst = memi; mem_regwrite = memw; wb_inst = wbi; wb_regwrite = wbw;
        lld_issue = iss; lld_done = done; lld_rd = lrd;
        issue_cycle();
    endtask

    task automatic check(input string name, input int d, input logic [5:0] got,
                         input logic [5:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cycle_no, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            expv_t e;
            e = exp_q.pop_front();
            cycle_no++;
            check("forward", 0, {2'b00, fwd_a}, e[0].fwd);
            check("stall",   0, {5'b0, stall_a}, {5'b0, e[0].stall});
            check("flush_ex",0, {5'b0, flush_a}, {5'b0, e[0].flush});
            check("sb_busy", 0, {5'b0, busy_a},  {5'b0, e[0].busy});
            check("forward", 1, fwd_b, e[1].fwd);
            check("stall",   1, {5'b0, stall_b}, {5'b0, e[1].stall});
            check("flush_ex",1, {5'b0, flush_b}, {5'b0, e[1].flush});
            check("sb_busy", 1, {5'b0, busy_b},  {5'b0, e[1].busy});
            check("forward", 2, fwd_c, e[2].fwd);
            check("stall",   2, {5'b0, stall_c}, {5'b0, e[2].stall});
            check("flush_ex",2, {5'b0, flush_c}, {5'b0, e[2].flush});
            check("sb_busy", 2, {5'b0, busy_c},  {5'b0, e[2].busy});
            $display("cyc %0d rst=%0b fwd=%h/%h/%h stall=%0b%0b%0b busy=%0b%0b%0b",
                     cycle_no, rst, fwd_a, fwd_b, fwd_c, stall_a, stall_b, stall_c,
                     busy_a, busy_b, busy_c);
        end
    end

    initial begin
        logic [31:0] z;
        z = '0;
        // Registers are unknown before the first edge; let reset settle.
        repeat (2) @(posedge clk);
        drv(1, z, z, 0, z, 0, z, 0, 0, 0, 0);
        drv(1, z, z, 0, z, 0, z, 0, 0, 0, 0);

        // Forwarding priority, x0 exclusion, third source.
        drv(0, z, mk(0, 5, 0, 0), 0, mk(5, 0, 0, 0), 1, mk(5, 0, 0, 0), 1, 0, 0, 0);
        drv(0, z, mk(0, 5, 0, 0), 0, mk(5, 0, 0, 0), 0, mk(5, 0, 0, 0), 1, 0, 0, 0);
        drv(0, z, mk(0, 0, 0, 7), 0, mk(0, 0, 0, 0), 1, mk(7, 0, 0, 0), 1, 0, 0, 0);

        // Load-use: load rd=3 in EX, ID src1=3, then bubbles.
        drv(0, mk(0, 0, 3, 0), mk(3, 0, 0, 0), 1, z, 0, z, 0, 0, 0, 0);
        repeat (5) drv(0, mk(0, 0, 3, 0), z, 0, z, 0, z, 0, 0, 0, 0);

        // Long-latency rd=9: issue in T, retire in T+4.
        drv(0, mk(0, 9, 0, 0), mk(9, 0, 0, 0), 0, z, 0, z, 0, 1, 0, 0);
        repeat (3) drv(0, mk(0, 9, 0, 0), z, 0, z, 0, z, 0, 0, 0, 0);
        drv(0, mk(0, 9, 0, 0), z, 0, z, 0, z, 0, 0, 1, 5'd9);
        repeat (2) drv(0, mk(0, 9, 0, 0), z, 0, z, 0, z, 0, 0, 0, 0);

        // Same-cycle set and clear of rd=9: set wins.
        drv(0, z, mk(9, 0, 0, 0), 0, z, 0, z, 0, 1, 1, 5'd9);
        drv(0, z, z, 0, z, 0, z, 0, 0, 0, 0);
        drv(0, z, z, 0, z, 0, z, 0, 0, 1, 5'd9);
        drv(0, z, z, 0, z, 0, z, 0, 0, 0, 0);

        // Reset pulsed during the second LSTALL cycle.
        drv(0, mk(0, 4, 0, 0), mk(4, 0, 0, 0), 1, z, 0, z, 0, 0, 0, 0);
        drv(0, mk(0, 4, 0, 0), z, 0, z, 0, z, 0, 0, 0, 0);
        drv(1, mk(0, 4, 0, 0), z, 0, z, 0, z, 0, 0, 0, 0);
        repeat (3) drv(0, mk(0, 4, 0, 0), z, 0, z, 0, z, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drv(($urandom_range(0, 99) < 2), rinst(), rinst(),
                ($urandom_range(0, 99) < 30), rinst(), ($urandom_range(0, 99) < 70),
                rinst(), ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 25), rreg());
        end

        // Drain the scoreboard queue with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
